muldiv_unit: RTL and testbench

//  Iterative N-bit multiply/divide unit with architectural HI/LO registers for the pipelined MIPS core.

---
 rtl/muldiv_pkg.sv | 30 +++
 rtl/muldiv_step.sv | 44 ++++
 rtl/muldiv_unit.sv | 207 ++++++++++++++++++++
 tb/tb_muldiv_unit.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   md_op_t    : operation code presented on muldiv_unit.op
//   md_state_t : control state of the unit (IDLE / CALC / FIX)
//   DIV0_QUOT_BIT : bit replicated across the quotient on divide-by-zero
package muldiv_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_t;

  // Divide-by-zero quotient is this bit replicated to the full width (all ones).
  localparam logic DIV0_QUOT_BIT = 1'b1;

  // True for the two signed arithmetic ops.
  function automatic logic md_is_signed(input md_op_t op);
    return (op == MULT) || (op == DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath on the {acc,q} register pair.
//   is_div  : 1 = restoring shift-subtract step, 0 = shift-add step
//   acc, q  : current high / low halves of the working register
//   m       : multiplicand (multiply) or divisor (divide)
//   acc_nxt, q_nxt : register pair after this iteration
// Multiply shifts right: after N steps {acc,q} is the 2N-bit product.
// Divide shifts left: after N steps q is the quotient and acc the remainder.
module muldiv_step #(
  parameter int unsigned N = 64
) (
  input  logic         is_div,
  input  logic [N-1:0] acc,
  input  logic [N-1:0] q,
  input  logic [N-1:0] m,
  output logic [N-1:0] acc_nxt,
  output logic [N-1:0] q_nxt
);

  logic [N:0] sum;
  logic [N:0] rem;
  logic [N:0] trial;

  always_comb begin
    sum     = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
    rem     = {acc, q[N-1]};
    trial   = rem - {1'b0, m};
    acc_nxt = acc;
    q_nxt   = q;
    if (is_div) begin
      // trial[N] is the borrow: set when the partial remainder is below the divisor.
      if (!trial[N]) begin
        acc_nxt = trial[N-1:0];
        q_nxt   = {q[N-2:0], 1'b1};
      end else begin
        acc_nxt = rem[N-1:0];
        q_nxt   = {q[N-2:0], 1'b0};
      end
    end else begin
      acc_nxt = sum[N:1];
      q_nxt   = {sum[0], q[N-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative N-bit multiply/divide unit with architectural HI/LO registers.
// Optional build macro: MULDIV_FAST_MUL_EN -- MULT/MULTU use a single N x N
// multiplier in FIX instead of N shift-add iterations; divides unchanged.
//   clk, reset    : clock, synchronous active-high reset
//   start, op     : operation valid in execute and its opcode
//   srca, srcb    : rs / rt operands after forwarding
//   flush         : cancel an in-flight operation
//   rd_req        : MFHI/MFLO in execute this cycle
//   hi, lo        : architectural HI/LO
//   busy          : unit in CALC or FIX
//   done          : one-cycle pulse after a mul/div result lands in HI/LO
//   stall_req     : combinational stall to the hazard unit
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  md_op_t       op,
  input  logic [N-1:0] srca,
  input  logic [N-1:0] srcb,
  input  logic         flush,
  input  logic         rd_req,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo,
  output logic         busy,
  output logic         done,
  output logic         stall_req
);

  localparam int unsigned CNTW = $clog2(N) + 1;

  md_state_t       state_q, state_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    acc_q, acc_d;
  logic [N-1:0]    qr_q, qr_d;
  logic [N-1:0]    m_q, m_d;
  logic [N-1:0]    srca_sv_q, srca_sv_d;
  logic [N-1:0]    hi_q, hi_d;
  logic [N-1:0]    lo_q, lo_d;
  logic            is_div_q, is_div_d;
  logic            neg_lo_q, neg_lo_d;
  logic            neg_hi_q, neg_hi_d;
  logic            div0_q, div0_d;
  logic            done_q, done_d;
  logic            busy_q, busy_d;

  logic [N-1:0]    acc_nxt, qr_nxt;
  logic            a_neg, b_neg;
  logic [N-1:0]    a_mag, b_mag;
  logic [2*N-1:0]  prod_raw, prod_fix;
  logic [N-1:0]    quot_fix, rem_fix;

  muldiv_step #(.N(N)) u_step (
    .is_div  (is_div_q),
    .acc     (acc_q),
    .q       (qr_q),
    .m       (m_q),
    .acc_nxt (acc_nxt),
    .q_nxt   (qr_nxt)
  );

  // Operand magnitudes and result sign correction.
  always_comb begin
    a_neg = md_is_signed(op) & srca[N-1];
    b_neg = md_is_signed(op) & srcb[N-1];
    a_mag = a_neg ? (~srca + 1'b1) : srca;
    b_mag = b_neg ? (~srcb + 1'b1) : srcb;
`ifdef MULDIV_FAST_MUL_EN
    prod_raw = {{N{1'b0}}, m_q} * {{N{1'b0}}, qr_q};
`else
    prod_raw = {acc_q, qr_q};
`endif
    prod_fix = neg_lo_q ? (~prod_raw + 1'b1) : prod_raw;
    quot_fix = neg_lo_q ? (~qr_q + 1'b1) : qr_q;
    rem_fix  = neg_hi_q ? (~acc_q + 1'b1) : acc_q;
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    qr_d      = qr_q;
    m_d       = m_q;
    srca_sv_d = srca_sv_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    div0_d    = div0_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // A flush in the same cycle drops the request.
        if (start && !flush) begin
          unique case (op)
            MULT, MULTU: begin
              acc_d    = '0;
              m_d      = a_mag;
              qr_d     = b_mag;
              cnt_d    = '0;
              is_div_d = 1'b0;
              neg_lo_d = a_neg ^ b_neg;
              neg_hi_d = 1'b0;
              div0_d   = 1'b0;
`ifdef MULDIV_FAST_MUL_EN
              state_d  = FIX;
`else
              state_d  = CALC;
`endif
            end
            DIV, DIVU: begin
              acc_d     = '0;
              qr_d      = a_mag;
              m_d       = b_mag;
              cnt_d     = '0;
              is_div_d  = 1'b1;
              neg_lo_d  = a_neg ^ b_neg;
              neg_hi_d  = a_neg;
              div0_d    = (srcb == '0);
              srca_sv_d = srca;
              state_d   = CALC;
            end
            MTHI: hi_d = srca;
            MTLO: lo_d = srca;
            default: ;
          endcase
        end
      end
      CALC: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          acc_d = acc_nxt;
          qr_d  = qr_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CNTW'(N)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!flush) begin
          done_d = 1'b1;
          if (!is_div_q) begin
            {hi_d, lo_d} = prod_fix;
          end else if (div0_q) begin
            lo_d = {N{DIV0_QUOT_BIT}};
            hi_d = srca_sv_q;
          end else begin
            lo_d = quot_fix;
            hi_d = rem_fix;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      qr_q      <= '0;
      m_q       <= '0;
      srca_sv_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      div0_q    <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      qr_q      <= qr_d;
      m_q       <= m_d;
      srca_sv_q <= srca_sv_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      div0_q    <= div0_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign hi        = hi_q;
  assign lo        = lo_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign stall_req = busy_q & (start | rd_req);

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (N=64) against a plain-arithmetic HI/LO model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int unsigned N = 64;
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;

  logic        clk = 1'b0;
  logic        reset, start, flush, rd_req;
  md_op_t      op;
  logic [63:0] srca, srcb, hi, lo;
  logic        busy, done, stall_req;

  int checks = 0;
  int errors = 0;
  logic [63:0] hi_m = '0, lo_m = '0;

  muldiv_unit #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
    .flush(flush), .rd_req(rd_req), .hi(hi), .lo(lo), .busy(busy), .done(done),
    .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Reference result of one operation applied to the architectural HI/LO.
  function automatic void model(input md_op_t o, input logic [63:0] a, input logic [63:0] b,
                                inout logic [63:0] h, inout logic [63:0] l);
    logic signed [127:0] sa, sb, sp;
    logic [127:0] up;
    logic signed [63:0] sa64, sb64;
    sa = {{64{a[63]}}, a};
    sb = {{64{b[63]}}, b};
    sa64 = a;
    sb64 = b;
    case (o)
      MULT:  begin sp = sa * sb; {h, l} = sp; end
      MULTU: begin up = {64'd0, a} * {64'd0, b}; {h, l} = up; end
      DIV: begin
        if (b == 0) begin l = '1; h = a; end
        else if (a == MIN64 && b == '1) begin l = MIN64; h = '0; end
        else begin l = sa64 / sb64; h = sa64 % sb64; end
      end
      DIVU: begin
        if (b == 0) begin l = '1; h = a; end
        else begin l = a / b; h = a % b; end
      end
      MTHI: h = a;
      MTLO: l = a;
      default: ;
    endcase
  endfunction

  function automatic int exp_lat(input md_op_t o);
`ifdef MULDIV_FAST_MUL_EN
    if (o == MULT || o == MULTU) return 2;
`endif
    return N + 2;
  endfunction

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Issue one mul/div and follow it to done; reports latency, busy cycles and done after the pulse.
  task automatic run_op(input md_op_t o, input logic [63:0] a, input logic [63:0] b,
                        output int lat, output int bcnt, output logic done_after);
    @(negedge clk);
    start = 1'b1; op = o; srca = a; srcb = b;
    @(negedge clk);
    start = 1'b0; srca = rnd64(); srcb = rnd64();
    lat = 0; bcnt = 0;
    for (int i = 1; i <= 200; i++) begin
      if (busy) bcnt++;
      if (done) begin lat = i; break; end
      @(negedge clk);
    end
    @(negedge clk);
    done_after = done;
  endtask

  task automatic check_result(input string name, input md_op_t o, input int lat, input int bcnt,
                              input logic done_after);
    checks++;
    if (hi !== hi_m) begin errors++; $display("FAIL %s hi: got %h expected %h", name, hi, hi_m); end
    checks++;
    if (lo !== lo_m) begin errors++; $display("FAIL %s lo: got %h expected %h", name, lo, lo_m); end
    checks++;
    if (lat !== exp_lat(o)) begin errors++; $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat(o)); end
    checks++;
    if (bcnt !== exp_lat(o) - 1) begin errors++; $display("FAIL %s busy cycles: got %0d expected %0d", name, bcnt, exp_lat(o) - 1); end
    checks++;
    if (done_after !== 1'b0) begin errors++; $display("FAIL %s done width: got extra cycle expected one-cycle pulse", name); end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; flush = 1'b0; rd_req = 1'b0; op = MULT; srca = '0; srcb = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    rd_req = 1'b1;
    @(negedge clk);
    checks++; if (hi !== 64'd0) begin errors++; $display("FAIL reset hi: got %h expected 0", hi); end
    checks++; if (lo !== 64'd0) begin errors++; $display("FAIL reset lo: got %h expected 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL reset idle rd_req stall: got %b expected 0", stall_req); end
    rd_req = 1'b0;
  endtask

  task automatic test_directed();
    md_op_t      ops[9];
    logic [63:0] as[9], bs[9];
    int lat, bcnt;
    logic da;
    ops[0] = MULT;  as[0] = -64'sd3;  bs[0] = 64'd5;
    ops[1] = MULTU; as[1] = '1;       bs[1] = 64'd2;
    ops[2] = DIV;   as[2] = -64'sd7;  bs[2] = 64'd2;
    ops[3] = DIVU;  as[3] = 64'd100;  bs[3] = 64'd7;
    ops[4] = DIVU;  as[4] = 64'd5;    bs[4] = 64'd0;
    ops[5] = DIV;   as[5] = MIN64;    bs[5] = '1;
    ops[6] = DIV;   as[6] = -64'sd9;  bs[6] = 64'd0;
    ops[7] = MULT;  as[7] = 64'd6;    bs[7] = 64'd7;
    ops[8] = MULT;  as[8] = MIN64;    bs[8] = MIN64;
    for (int k = 0; k < 9; k++) begin
      run_op(ops[k], as[k], bs[k], lat, bcnt, da);
      model(ops[k], as[k], bs[k], hi_m, lo_m);
      check_result($sformatf("directed%0d", k), ops[k], lat, bcnt, da);
    end
  endtask

  task automatic test_mt_stall();
    logic [63:0] a, b, v;
    logic got_done;
    v = rnd64();
    @(negedge clk); start = 1'b1; op = MTHI; srca = v;
    @(negedge clk); start = 1'b1; op = MTLO; srca = 64'h1234;
    model(MTHI, v, '0, hi_m, lo_m);
    checks++; if (hi !== hi_m) begin errors++; $display("FAIL mthi hi: got %h expected %h", hi, hi_m); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mthi busy: got %b expected 0", busy); end
    @(negedge clk); start = 1'b0;
    model(MTLO, 64'h1234, '0, hi_m, lo_m);
    checks++; if (lo !== 64'h1234) begin errors++; $display("FAIL mtlo lo: got %h expected 1234", lo); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mtlo done: got %b expected 0", done); end
    a = rnd64(); b = {32'd0, $urandom} | 64'd1;
    start = 1'b1; op = DIVU; srca = a; srcb = b;
    @(negedge clk); start = 1'b0; rd_req = 1'b1;
    got_done = 1'b0;
    for (int i = 1; i <= 200; i++) begin
      if (done) begin got_done = 1'b1; break; end
      checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL busy rd stall: got %b expected 1", stall_req); end
      checks++; if (lo !== 64'h1234) begin errors++; $display("FAIL busy lo hold: got %h expected 1234", lo); end
      @(negedge clk);
    end
    checks++; if (got_done !== 1'b1) begin errors++; $display("FAIL mt divu done: got none expected pulse"); end
    model(DIVU, a, b, hi_m, lo_m);
    checks++; if (lo !== lo_m) begin errors++; $display("FAIL mt divu lo: got %h expected %h", lo, lo_m); end
    checks++; if (stall_req !== 1'b0) begin errors++; $display("FAIL idle rd stall: got %b expected 0", stall_req); end
    rd_req = 1'b0;
  endtask

  task automatic test_flush();
    int fcyc[2];
    int ndone;
    logic [63:0] v;
    fcyc[0] = 10; fcyc[1] = N + 1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); start = 1'b1; op = DIV; srca = rnd64(); srcb = 64'd3;
      @(negedge clk); start = 1'b0;
      for (int i = 1; i < fcyc[k]; i++) @(negedge clk);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL flush%0d pre busy: got %b expected 1", k, busy); end
      flush = 1'b1;
      @(negedge clk); flush = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush%0d busy: got %b expected 0", k, busy); end
      ndone = 0;
      for (int i = 0; i < 80; i++) begin if (done) ndone++; @(negedge clk); end
      checks++; if (ndone !== 0) begin errors++; $display("FAIL flush%0d done: got %0d pulses expected 0", k, ndone); end
      checks++; if ({hi, lo} !== {hi_m, lo_m}) begin errors++; $display("FAIL flush%0d hilo: got %h_%h expected %h_%h", k, hi, lo, hi_m, lo_m); end
    end
    start = 1'b1; flush = 1'b1; op = MULT; srca = 64'd9; srcb = 64'd9;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL flush+start busy: got %b expected 0", busy); end
    v = rnd64();
    start = 1'b1; flush = 1'b1; op = MTHI; srca = v;
    @(negedge clk); start = 1'b0; flush = 1'b0;
    checks++; if (hi !== hi_m) begin errors++; $display("FAIL flush+mthi hi: got %h expected %h", hi, hi_m); end
  endtask

  task automatic test_start_ignored_reset();
    logic [63:0] a, b;
    int lat, ndone;
    logic got;
    a = rnd64(); b = {48'd0, 16'($urandom)} | 64'd1;
    @(negedge clk); start = 1'b1; op = DIVU; srca = a; srcb = b;
    @(negedge clk); start = 1'b0;
    lat = 0;
    for (int i = 1; i <= 200; i++) begin
      if (i == 3) begin
        start = 1'b1; op = MULTU; srca = rnd64(); srcb = rnd64();
        #1;
        checks++; if (stall_req !== 1'b1) begin errors++; $display("FAIL busy start stall: got %b expected 1", stall_req); end
      end
      if (i == 4) start = 1'b0;
      if (done) begin lat = i; break; end
      @(negedge clk);
    end
    model(DIVU, a, b, hi_m, lo_m);
    checks++; if ({hi, lo} !== {hi_m, lo_m}) begin errors++; $display("FAIL ignored start result: got %h_%h expected %h_%h", hi, lo, hi_m, lo_m); end
    checks++; if (lat !== N + 2) begin errors++; $display("FAIL ignored start latency: got %0d expected %0d", lat, N + 2); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored start busy after: got %b expected 0", busy); end

    @(negedge clk); start = 1'b1; op = DIV; srca = rnd64(); srcb = 64'd5;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    hi_m = '0; lo_m = '0;
    checks++; if ({hi, lo} !== 128'd0) begin errors++; $display("FAIL mid reset hilo: got %h_%h expected 0", hi, lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid reset busy: got %b expected 0", busy); end
    ndone = 0;
    for (int i = 0; i < 80; i++) begin if (done) ndone++; @(negedge clk); end
    got = (ndone == 0);
    checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid reset done: got %0d pulses expected 0", ndone); end
  endtask

  task automatic test_random();
    md_op_t o;
    logic [63:0] a, b;
    int lat, bcnt;
    logic da;
    for (int k = 0; k < 30; k++) begin
      o = md_op_t'(3'($urandom_range(0, 5)));
      a = rnd64();
      case ($urandom_range(0, 3))
        0: b = '0;
        1: b = 64'($urandom_range(1, 15));
        2: b = -64'($urandom_range(1, 15));
        default: b = rnd64();
      endcase
      if ($urandom_range(0, 3) == 0) a = {32'd0, $urandom};
      if (o == MTHI || o == MTLO) begin
        @(negedge clk); start = 1'b1; op = o; srca = a; srcb = b;
        @(negedge clk); start = 1'b0;
        model(o, a, b, hi_m, lo_m);
        checks++; if ({hi, lo} !== {hi_m, lo_m}) begin errors++; $display("FAIL rand%0d move: got %h_%h expected %h_%h", k, hi, lo, hi_m, lo_m); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand%0d move busy: got %b expected 0", k, busy); end
      end else begin
        run_op(o, a, b, lat, bcnt, da);
        model(o, a, b, hi_m, lo_m);
        check_result($sformatf("rand%0d_op%0d", k, o), o, lat, bcnt, da);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_mt_stall();
    test_flush();
    test_start_ignored_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
